// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the five-stage MIPS core:
//   - opcode constants and instruction field positions
//   - sb_entry_t : one hazard scoreboard slot {valid, destination register}
//   - src_match  : true when a source register collides with a live slot
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_RTYPE     = 6'b000000;
  localparam logic [5:0] OP_LW        = 6'b100011;
  localparam logic [5:0] OP_SW        = 6'b101011;
  localparam logic [5:0] OP_BEQ       = 6'b000100;
  localparam logic [2:0] OP_ITYPE_PFX = 3'b001;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;

  typedef logic [4:0] reg_idx_t;

  // "reg" is a reserved word, so the register field is called idx.
  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, idx: 5'd0};

  // $0 is hard-wired, so a read of it can never depend on an older write.
  function automatic logic src_match(sb_entry_t e, reg_idx_t src);
    return e.valid && (src != 5'd0) && (e.idx == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of destination registers for instructions in EX/MEM/WB,
// compared against up to two decode-stage source registers.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   push_valid_i      : decode instruction accepted and writes push_reg_i
//   push_reg_i        : destination register of the accepted instruction
//   src_a_en_i/src_a_i: first source (rs) enable and register
//   src_b_en_i/src_b_i: second source (rt) enable and register
//   hit_o             : some enabled source matches a valid slot
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push_valid_i,
  input  reg_idx_t push_reg_i,
  input  logic     src_a_en_i,
  input  reg_idx_t src_a_i,
  input  logic     src_b_en_i,
  input  reg_idx_t src_b_i,
  output logic     hit_o
);

  sb_entry_t [DEPTH-1:0] entry_q;

  // NOTE: every slot is reset, not just a read pointer: a stale valid bit
  // would stall the first instruction after reset on a phantom hazard.
  // NOTE: non-blocking assignments so every slot shifts from its old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q[0] <= push_valid_i ? '{valid: 1'b1, idx: push_reg_i} : SB_EMPTY;
      for (int i = 1; i < DEPTH; i++) begin
        entry_q[i] <= entry_q[i-1];
      end
    end
  end

  // NOTE: hit_o gets its default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((src_a_en_i && src_match(entry_q[i], src_a_i)) ||
          (src_b_en_i && src_match(entry_q[i], src_b_i))) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall controller beside decode for a forwarding-less five-stage MIPS core.
// Holds the front end on read-after-write hazards and holds PC / squashes
// fetch for BRANCH_STALL cycles on every beq.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   ip_instruction      : IF/ID instruction in decode
//   ip_R_format .. Beq  : decode format flags for ip_instruction
//   op_pc_hold          : PC does not advance (a taken redirect overrides)
//   op_ifid_hold        : IF/ID keeps its contents
//   op_ifid_flush       : IF/ID loads a NOP
//   op_bubble           : control pipeline register / ID/EX capture a NOP
//   op_stall_count      : saturating count of cycles with op_pc_hold high
// All op_* outputs read 0 while reset is high.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int HAZARD_DEPTH = 3,
  parameter int BRANCH_STALL = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ip_instruction,
  input  logic        ip_R_format,
  input  logic        ip_I_format,
  input  logic        ip_Lw,
  input  logic        ip_Sw,
  input  logic        ip_Beq,
  output logic        op_pc_hold,
  output logic        op_ifid_hold,
  output logic        op_ifid_flush,
  output logic        op_bubble,
  output logic [31:0] op_stall_count
);

  localparam int CNT_W = (BRANCH_STALL > 1) ? $clog2(BRANCH_STALL) : 1;
  localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(BRANCH_STALL - 1);

  typedef enum logic {ST_IDLE, ST_BR_WAIT} br_state_e;

  br_state_e        state_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic     is_nop;
  reg_idx_t rs, rt, rd;
  logic     use_rs, use_rt;
  reg_idx_t dest;
  logic     has_dest;
  logic     sb_hit, data_hazard, accepted, br_start, br_window, pc_hold;

  // ---------------------------------------------------------------- decode
  assign is_nop = (ip_instruction == 32'h0);
  assign rs     = ip_instruction[RS_MSB:RS_LSB];
  assign rt     = ip_instruction[RT_MSB:RT_LSB];
  assign rd     = ip_instruction[RD_MSB:RD_LSB];

  assign use_rs = !is_nop && (ip_R_format || ip_Sw || ip_Beq || ip_Lw || ip_I_format);
  assign use_rt = !is_nop && (ip_R_format || ip_Sw || ip_Beq);

  // I-format ALU ops do not write the register file in this core.
  always_comb begin
    dest = 5'd0;
    if (!is_nop && ip_R_format) begin
      dest = rd;
    end else if (!is_nop && ip_Lw) begin
      dest = rt;
    end
  end
  assign has_dest = (dest != 5'd0);

  // ------------------------------------------------------------ scoreboard
  hazard_scoreboard #(
    .DEPTH(HAZARD_DEPTH)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .push_valid_i(accepted && has_dest),
    .push_reg_i  (dest),
    .src_a_en_i  (use_rs),
    .src_a_i     (rs),
    .src_b_en_i  (use_rt),
    .src_b_i     (rt),
    .hit_o       (sb_hit)
  );

  // Decode only holds a flushed NOP during the branch window; gating on
  // IDLE keeps a stray flag from turning the window into a data stall.
  assign data_hazard = sb_hit && (state_q == ST_IDLE);
  assign accepted    = !data_hazard && (state_q == ST_IDLE);
  assign br_start    = accepted && ip_Beq && !is_nop;
  assign br_window   = br_start || (state_q == ST_BR_WAIT);
  assign pc_hold     = data_hazard || br_window;

  // ------------------------------------------------------------ branch FSM
  // The beq decode cycle is the first hold cycle, so BR_WAIT lasts
  // BRANCH_STALL-1 cycles, counted down from BR_LOAD to 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      br_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_start) begin
            br_cnt_q <= BR_LOAD;
            if (BRANCH_STALL > 1) begin
              state_q <= ST_BR_WAIT;
            end
          end
        end
        ST_BR_WAIT: begin
          br_cnt_q <= br_cnt_q - 1'b1;
          if (br_cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          br_cnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------- stall count
  assign stall_cnt_d = (pc_hold && (stall_cnt_q != 32'hFFFF_FFFF))
                     ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // --------------------------------------------------------------- outputs
  assign op_pc_hold     = !reset && pc_hold;
  assign op_ifid_hold   = !reset && data_hazard;
  assign op_bubble      = !reset && data_hazard;
  assign op_ifid_flush  = !reset && br_window;
  assign op_stall_count = reset ? 32'd0 : stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Table-driven bench: one record per clock cycle with the decode inputs and
// the hand-computed outputs for that cycle, plus two reset corner sequences.
// Inputs change 1 ns after the rising edge; outputs are read on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ip_instruction = 32'h0;
  logic        ip_R_format = 1'b0;
  logic        ip_I_format = 1'b0;
  logic        ip_Lw = 1'b0;
  logic        ip_Sw = 1'b0;
  logic        ip_Beq = 1'b0;
  logic        op_pc_hold, op_ifid_hold, op_ifid_flush, op_bubble;
  logic [31:0] op_stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hazard_stall_ctrl #(
    .HAZARD_DEPTH(3),
    .BRANCH_STALL(3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ip_instruction(ip_instruction),
    .ip_R_format   (ip_R_format),
    .ip_I_format   (ip_I_format),
    .ip_Lw         (ip_Lw),
    .ip_Sw         (ip_Sw),
    .ip_Beq        (ip_Beq),
    .op_pc_hold    (op_pc_hold),
    .op_ifid_hold  (op_ifid_hold),
    .op_ifid_flush (op_ifid_flush),
    .op_bubble     (op_bubble),
    .op_stall_count(op_stall_count)
  );

  // Flag encodings {R, I, Lw, Sw, Beq}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_R    = 5'b10000;
  localparam logic [4:0] F_I    = 5'b01000;
  localparam logic [4:0] F_LW   = 5'b00100;
  localparam logic [4:0] F_SW   = 5'b00010;
  localparam logic [4:0] F_BEQ  = 5'b00001;

  // Expected output sets {pc_hold, ifid_hold, ifid_flush, bubble}
  localparam logic [3:0] E_NONE = 4'b0000;
  localparam logic [3:0] E_DATA = 4'b1101;
  localparam logic [3:0] E_BR   = 4'b1010;

  // Instructions
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] ADD3   = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] SUB5   = 32'h0064_2822; // sub  $5,$3,$4
  localparam logic [31:0] LW8    = 32'h8D28_0000; // lw   $8,0($9)
  localparam logic [31:0] SW8    = 32'hAD48_0004; // sw   $8,4($10)
  localparam logic [31:0] ADD11  = 32'h018D_5820; // add  $11,$12,$13
  localparam logic [31:0] ADD14  = 32'h01F0_7020; // add  $14,$15,$16
  localparam logic [31:0] ADD0   = 32'h0022_0020; // add  $0,$1,$2
  localparam logic [31:0] ADD4   = 32'h0000_2020; // add  $4,$0,$0
  localparam logic [31:0] BEQ12  = 32'h1022_0003; // beq  $1,$2,3
  localparam logic [31:0] ADD1   = 32'h018D_0820; // add  $1,$12,$13
  localparam logic [31:0] ADDI6  = 32'h20E6_0001; // addi $6,$7,1
  localparam logic [31:0] ADD9   = 32'h00C6_4820; // add  $9,$6,$6
  localparam logic [31:0] ADD7   = 32'h0022_3820; // add  $7,$1,$2

  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  flags;
    logic [3:0]  exp;
    logic [31:0] count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [31:0] instr,
                              input logic [4:0] flags, input logic [3:0] exp,
                              input int count);
    vec_t v;
    v.rst   = rst;
    v.instr = instr;
    v.flags = flags;
    v.exp   = exp;
    v.count = 32'(count);
    return v;
  endfunction

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, tag, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int tag);
    reset          = v.rst;
    ip_instruction = v.instr;
    {ip_R_format, ip_I_format, ip_Lw, ip_Sw, ip_Beq} = v.flags;
    @(negedge clock);
    check("pc_hold",     tag, 32'(op_pc_hold),    32'(v.exp[3]));
    check("ifid_hold",   tag, 32'(op_ifid_hold),  32'(v.exp[2]));
    check("ifid_flush",  tag, 32'(op_ifid_flush), 32'(v.exp[1]));
    check("bubble",      tag, 32'(op_bubble),     32'(v.exp[0]));
    check("stall_count", tag, op_stall_count,     v.count);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset: outputs forced low even with a live instruction in decode
    tbl.push_back(mk(1, ADD3,  F_R,    E_NONE, 0));   // 0
    tbl.push_back(mk(1, NOP,   F_NONE, E_NONE, 0));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 0));
    // Back-to-back RAW: 3-cycle stall
    tbl.push_back(mk(0, ADD3,  F_R,    E_NONE, 0));   // 3
    tbl.push_back(mk(0, SUB5,  F_R,    E_DATA, 0));
    tbl.push_back(mk(0, SUB5,  F_R,    E_DATA, 1));
    tbl.push_back(mk(0, SUB5,  F_R,    E_DATA, 2));
    tbl.push_back(mk(0, SUB5,  F_R,    E_NONE, 3));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 3));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 3));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 3));
    // lw -> sw adjacent: 3-cycle stall
    tbl.push_back(mk(0, LW8,   F_LW,   E_NONE, 3));   // 11
    tbl.push_back(mk(0, SW8,   F_SW,   E_DATA, 3));
    tbl.push_back(mk(0, SW8,   F_SW,   E_DATA, 4));
    tbl.push_back(mk(0, SW8,   F_SW,   E_DATA, 5));
    tbl.push_back(mk(0, SW8,   F_SW,   E_NONE, 6));
    // lw, two independent adds, sw: 1-cycle stall
    tbl.push_back(mk(0, LW8,   F_LW,   E_NONE, 6));   // 16
    tbl.push_back(mk(0, ADD11, F_R,    E_NONE, 6));
    tbl.push_back(mk(0, ADD14, F_R,    E_NONE, 6));
    tbl.push_back(mk(0, SW8,   F_SW,   E_DATA, 6));
    tbl.push_back(mk(0, SW8,   F_SW,   E_NONE, 7));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 7));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 7));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 7));
    // Writes to $0 are never tracked
    tbl.push_back(mk(0, ADD0,  F_R,    E_NONE, 7));   // 24
    tbl.push_back(mk(0, ADD4,  F_R,    E_NONE, 7));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 7));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 7));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 7));
    // Hazard-free beq: 3-cycle branch window
    tbl.push_back(mk(0, BEQ12, F_BEQ,  E_BR,   7));   // 29
    tbl.push_back(mk(0, NOP,   F_NONE, E_BR,   8));
    tbl.push_back(mk(0, NOP,   F_NONE, E_BR,   9));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 10));
    // beq after a writer of $1: data stall then branch window
    tbl.push_back(mk(0, ADD1,  F_R,    E_NONE, 10));  // 33
    tbl.push_back(mk(0, BEQ12, F_BEQ,  E_DATA, 10));
    tbl.push_back(mk(0, BEQ12, F_BEQ,  E_DATA, 11));
    tbl.push_back(mk(0, BEQ12, F_BEQ,  E_DATA, 12));
    tbl.push_back(mk(0, BEQ12, F_BEQ,  E_BR,   13));
    tbl.push_back(mk(0, NOP,   F_NONE, E_BR,   14));
    tbl.push_back(mk(0, NOP,   F_NONE, E_BR,   15));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 16));
    // addi has no destination: reader of $6 does not stall
    tbl.push_back(mk(0, ADDI6, F_I,    E_NONE, 16));  // 41
    tbl.push_back(mk(0, ADD9,  F_R,    E_NONE, 16));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 16));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 16));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 16));
    // addi does read rs: stalls behind a writer of $7
    tbl.push_back(mk(0, ADD7,  F_R,    E_NONE, 16));  // 46
    tbl.push_back(mk(0, ADDI6, F_I,    E_DATA, 16));
    tbl.push_back(mk(0, ADDI6, F_I,    E_DATA, 17));
    tbl.push_back(mk(0, ADDI6, F_I,    E_DATA, 18));
    tbl.push_back(mk(0, ADDI6, F_I,    E_NONE, 19));
    tbl.push_back(mk(0, NOP,   F_NONE, E_NONE, 19));

    @(posedge clock);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i], i);
    end

    // Reset in cycle 2 of a data stall: state and count clear, $3 is gone
    step(mk(0, ADD3,  F_R,    E_NONE, 19), 100);
    step(mk(0, SUB5,  F_R,    E_DATA, 19), 101);
    step(mk(1, SUB5,  F_R,    E_NONE, 0),  102);
    step(mk(0, SUB5,  F_R,    E_NONE, 0),  103);
    step(mk(0, NOP,   F_NONE, E_NONE, 0),  104);

    // Reset in BR_WAIT: FSM back to IDLE, next beq gets a full window
    step(mk(0, BEQ12, F_BEQ,  E_BR,   0),  200);
    step(mk(0, NOP,   F_NONE, E_BR,   1),  201);
    step(mk(1, NOP,   F_NONE, E_NONE, 0),  202);
    step(mk(0, NOP,   F_NONE, E_NONE, 0),  203);
    step(mk(0, BEQ12, F_BEQ,  E_BR,   0),  204);
    step(mk(0, NOP,   F_NONE, E_BR,   1),  205);
    step(mk(0, NOP,   F_NONE, E_BR,   2),  206);
    step(mk(0, NOP,   F_NONE, E_NONE, 3),  207);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
